pipe_issue_ctrl: RTL and testbench

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

---
 rtl/pipe_issue_ctrl_pkg.sv | 15 +
 rtl/pipe_issue_ctrl_rr_arbiter.sv | 42 ++++
 rtl/pipe_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_issue_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared definitions for the pipeline issue controller.
// ID layout (LSB first): requester index [IDX_W-1:0], generation bit [IDX_W],
// zero padding above. The generation bit separates a reissued transaction
// from a stale completion of that requester's previous one.
package pipe_issue_ctrl_pkg;

  localparam int ADDRESS_WIDTH = 8;
  localparam int ID_WIDTH      = 4;

  function automatic logic [ID_WIDTH-1:0] make_id(input logic gen, input int idx,
                                                  input int idx_w);
    return ID_WIDTH'(idx) | (ID_WIDTH'(gen) << idx_w);
  endfunction

endpackage

// File: rtl/pipe_issue_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant.
//   req     - request vector (already qualified by the caller)
//   advance - when high and a grant is given, the pointer moves past the winner
//   grant   - one-hot grant, combinational
// The search starts at ptr_q (0 after reset) and wraps from N-1 to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    int   k;
    logic found;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = int'(ptr_q) + off;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
        if (advance) ptr_d = (k == N - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// pipe_issue_ctrl: issues requests from NUM_REQ requesters into a pipeline
// head, tracks one outstanding transaction per requester, routes completions
// back and turns requester cancels into pipeline flushes.
//   req_valid/req_address/req_ready - requester issue handshake (ready one-hot)
//   cancel                          - per-requester abort of outstanding txn
//   pipe_valid/pipe_address/pipe_id - first pipeline stage, held while pipe_stall
//   pipe_flush/pipe_flush_id        - one flush per cycle
//   done_valid/done_id              - completion from the pipeline tail
//   resp_valid/resp_idx             - completion delivered to a requester
//   busy                            - requester has an outstanding txn
//   stale_cnt                       - saturating count of dropped completions
module pipe_issue_ctrl
  import pipe_issue_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0]                 cancel,
  output logic [ADDRESS_WIDTH-1:0]           pipe_address,
  output logic [ID_WIDTH-1:0]                pipe_id,
  output logic                               pipe_valid,
  input  logic                               pipe_stall,
  output logic                               pipe_flush,
  output logic [ID_WIDTH-1:0]                pipe_flush_id,
  input  logic                               done_valid,
  input  logic [ID_WIDTH-1:0]                done_id,
  output logic                               resp_valid,
  output logic [IDX_W-1:0]                   resp_idx,
  output logic [NUM_REQ-1:0]                 busy,
  output logic [7:0]                         stale_cnt
);

  if (NUM_REQ < 2 || ID_WIDTH < IDX_W + 1) begin : g_cfg_chk
    $error("pipe_issue_ctrl: need NUM_REQ >= 2 and ID_WIDTH >= clog2(NUM_REQ)+1");
  end

  logic [NUM_REQ-1:0]                busy_q, busy_d, gen_q, gen_d, pend_q, pend_d;
  logic                              pipe_valid_q, pipe_valid_d;
  logic [ADDRESS_WIDTH-1:0]          pipe_addr_q, pipe_addr_d;
  logic [ID_WIDTH-1:0]               pipe_id_q, pipe_id_d;
  logic                              flush_q, flush_d;
  logic [ID_WIDTH-1:0]               flush_id_q, flush_id_d;
  logic                              resp_valid_q, resp_valid_d;
  logic [IDX_W-1:0]                  resp_idx_q, resp_idx_d;
  logic [7:0]                        stale_q, stale_d;

  logic [NUM_REQ-1:0][ID_WIDTH-1:0]  cur_id;
  logic [NUM_REQ-1:0]                eligible, arb_req, grant;
  logic [NUM_REQ-1:0]                done_hit, cxl_vec, flush_sel;
  logic                              slot_free;

  // gen_q toggles at grant, so the outstanding txn carries the inverted bit.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cur_id[i] = make_id(~gen_q[i], i, IDX_W);
  end

  // Grants are masked while reset is asserted so req_ready is low immediately.
  assign slot_free = !pipe_valid_q || !pipe_stall;
  assign eligible  = req_valid & ~busy_q & ~cancel;
  assign arb_req   = (slot_free && reset_n) ? eligible : '0;
  assign req_ready = grant;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (arb_req),
    .advance (slot_free),
    .grant   (grant)
  );

  always_comb begin
    busy_d       = busy_q;
    gen_d        = gen_q;
    pend_d       = pend_q;
    pipe_valid_d = pipe_valid_q;
    pipe_addr_d  = pipe_addr_q;
    pipe_id_d    = pipe_id_q;
    flush_d      = 1'b0;
    flush_id_d   = flush_id_q;
    resp_valid_d = 1'b0;
    resp_idx_d   = resp_idx_q;
    stale_d      = stale_q;

    // Completions: match against the live ID of a busy requester.
    for (int i = 0; i < NUM_REQ; i++)
      done_hit[i] = done_valid && busy_q[i] && (done_id == cur_id[i]);
    if (done_valid) begin
      if (|done_hit) begin
        resp_valid_d = 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
          if (done_hit[i]) resp_idx_d = IDX_W'(i);
      end else if (stale_q != 8'hFF) begin
        stale_d = stale_q + 8'd1;
      end
    end
    busy_d = busy_d & ~done_hit;

    // Cancels: new and pending merge; a same-cycle completion wins.
    // Pending requesters stay busy until their flush goes out.
    cxl_vec   = ((cancel & busy_q) | pend_q) & busy_q & ~done_hit;
    flush_sel = cxl_vec & (~cxl_vec + NUM_REQ'(1));
    pend_d    = cxl_vec & ~flush_sel;
    if (|cxl_vec) begin
      flush_d = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (flush_sel[i]) flush_id_d = cur_id[i];
      busy_d = busy_d & ~flush_sel;
    end

    // Issue slot.
    if (slot_free) begin
      pipe_valid_d = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          pipe_valid_d = 1'b1;
          pipe_addr_d  = req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          pipe_id_d    = make_id(gen_q[i], i, IDX_W);
          busy_d[i]    = 1'b1;
          gen_d[i]     = ~gen_q[i];
        end
      end
    end else begin
      // Held txn whose requester is cancelling never enters the pipeline.
      for (int i = 0; i < NUM_REQ; i++)
        if (cxl_vec[i] && cur_id[i] == pipe_id_q) pipe_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q       <= '0;
      gen_q        <= '0;
      pend_q       <= '0;
      pipe_valid_q <= 1'b0;
      pipe_addr_q  <= '0;
      pipe_id_q    <= '0;
      flush_q      <= 1'b0;
      flush_id_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_idx_q   <= '0;
      stale_q      <= '0;
    end else begin
      busy_q       <= busy_d;
      gen_q        <= gen_d;
      pend_q       <= pend_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_id_q    <= pipe_id_d;
      flush_q      <= flush_d;
      flush_id_q   <= flush_id_d;
      resp_valid_q <= resp_valid_d;
      resp_idx_q   <= resp_idx_d;
      stale_q      <= stale_d;
    end
  end

  assign pipe_valid    = pipe_valid_q;
  assign pipe_address  = pipe_addr_q;
  assign pipe_id       = pipe_id_q;
  assign pipe_flush    = flush_q;
  assign pipe_flush_id = flush_id_q;
  assign resp_valid    = resp_valid_q;
  assign resp_idx      = resp_idx_q;
  assign busy          = busy_q;
  assign stale_cnt     = stale_q;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Directed bench for pipe_issue_ctrl (NUM_REQ=4, ADDRESS_WIDTH=8, ID_WIDTH=4).
module tb_pipe_issue_ctrl;
  import pipe_issue_ctrl_pkg::*;

  localparam int N  = 4;
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = ID_WIDTH;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_address;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      cancel;
  logic [AW-1:0]     pipe_address;
  logic [IW-1:0]     pipe_id;
  logic              pipe_valid;
  logic              pipe_stall;
  logic              pipe_flush;
  logic [IW-1:0]     pipe_flush_id;
  logic              done_valid;
  logic [IW-1:0]     done_id;
  logic              resp_valid;
  logic [1:0]        resp_idx;
  logic [N-1:0]      busy;
  logic [7:0]        stale_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_issue_ctrl #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_address   (req_address),
    .req_ready     (req_ready),
    .cancel        (cancel),
    .pipe_address  (pipe_address),
    .pipe_id       (pipe_id),
    .pipe_valid    (pipe_valid),
    .pipe_stall    (pipe_stall),
    .pipe_flush    (pipe_flush),
    .pipe_flush_id (pipe_flush_id),
    .done_valid    (done_valid),
    .done_id       (done_id),
    .resp_valid    (resp_valid),
    .resp_idx      (resp_idx),
    .busy          (busy),
    .stale_cnt     (stale_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] v);
    req_address[i*AW +: AW] = v;
  endtask

  task automatic do_reset();
    req_valid  = '0;
    cancel     = '0;
    done_valid = 1'b0;
    done_id    = '0;
    pipe_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    req_valid   = 4'hF;
    req_address = '0;
    cancel      = '0;
    pipe_stall  = 1'b0;
    done_valid  = 1'b0;
    done_id     = '0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_pipe_valid", pipe_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stale", stale_cnt, 0);
    chk("rst_flush", pipe_flush, 0);
    chk("rst_resp", resp_valid, 0);
    do_reset();

    // Single issue, completion, reissue with toggled generation.
    set_addr(0, 8'h10);
    req_valid = 4'b0001;
    #1 chk("a_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("a_valid", pipe_valid, 1);
    chk("a_addr", pipe_address, 8'h10);
    chk("a_id", pipe_id, 4'h0);
    chk("a_busy", busy, 4'b0001);
    tick();
    chk("a_idle", pipe_valid, 0);
    done_valid = 1'b1; done_id = 4'h0;
    tick();
    done_valid = 1'b0;
    chk("a_resp", resp_valid, 1);
    chk("a_resp_idx", resp_idx, 0);
    chk("a_busy_clr", busy, 0);
    set_addr(0, 8'h11);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("a_reissue_id", pipe_id, 4'h4);
    chk("a_reissue_addr", pipe_address, 8'h11);
    done_valid = 1'b1; done_id = 4'h4;
    tick();
    done_valid = 1'b0;
    chk("a_resp2", resp_valid, 1);
    chk("a_stale0", stale_cnt, 0);

    // Round-robin across all requesters from reset.
    do_reset();
    for (int k = 0; k < N; k++) set_addr(k, AW'(8'h20 + k));
    req_valid = 4'hF;
    for (int k = 0; k < N; k++) begin
      #1 chk("b_ready", req_ready, 32'(1 << k));
      tick();
      chk("b_id", pipe_id, 32'(k));
      chk("b_addr", pipe_address, 32'(8'h20 + k));
    end
    #1 chk("b_ready_none", req_ready, 0);
    chk("b_busy", busy, 4'hF);
    tick();
    chk("b_idle", pipe_valid, 0);
    req_valid = '0;

    // Cancel requester 2, then its late completion is stale.
    cancel = 4'b0100;
    tick();
    cancel = '0;
    chk("c_flush", pipe_flush, 1);
    chk("c_flush_id", pipe_flush_id, 4'h2);
    chk("c_busy", busy, 4'b1011);
    tick();
    chk("c_flush_off", pipe_flush, 0);
    done_valid = 1'b1; done_id = 4'h2;
    tick();
    done_valid = 1'b0;
    chk("c_no_resp", resp_valid, 0);
    chk("c_stale", stale_cnt, 1);

    // Two cancels: ascending flushes on consecutive cycles.
    cancel = 4'b1001;
    tick();
    cancel = '0;
    chk("d_flush0", pipe_flush, 1);
    chk("d_flush0_id", pipe_flush_id, 4'h0);
    chk("d_busy0", busy, 4'b1010);
    tick();
    chk("d_flush1", pipe_flush, 1);
    chk("d_flush1_id", pipe_flush_id, 4'h3);
    chk("d_busy1", busy, 4'b0010);
    tick();
    chk("d_flush_off", pipe_flush, 0);

    // Completion beats same-cycle cancel.
    done_valid = 1'b1; done_id = 4'h1; cancel = 4'b0010;
    tick();
    done_valid = 1'b0; cancel = '0;
    chk("e_resp", resp_valid, 1);
    chk("e_resp_idx", resp_idx, 1);
    chk("e_no_flush", pipe_flush, 0);
    chk("e_busy", busy, 0);
    cancel = 4'b0001;
    tick();
    cancel = '0;
    chk("e_idle_cancel", pipe_flush, 0);

    // Stale counter saturates.
    done_valid = 1'b1; done_id = 4'hF;
    repeat (260) tick();
    done_valid = 1'b0;
    chk("f_stale_sat", stale_cnt, 255);

    // Stall holds the output slot.
    do_reset();
    chk("g_stale_rst", stale_cnt, 0);
    set_addr(1, 8'h22);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    chk("g_id", pipe_id, 4'h1);
    chk("g_addr", pipe_address, 8'h22);
    pipe_stall = 1'b1;
    set_addr(0, 8'h30);
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      #1 chk("g_stall_ready", req_ready, 0);
      tick();
      chk("g_stall_valid", pipe_valid, 1);
      chk("g_stall_addr", pipe_address, 8'h22);
      chk("g_stall_id", pipe_id, 4'h1);
    end
    pipe_stall = 1'b0;
    #1 chk("g_unstall_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("g_next_addr", pipe_address, 8'h30);
    chk("g_next_id", pipe_id, 4'h0);

    // Cancel of the transaction held in a stalled slot.
    pipe_stall = 1'b1;
    cancel = 4'b0001;
    tick();
    cancel = '0;
    pipe_stall = 1'b0;
    chk("h_valid_drop", pipe_valid, 0);
    chk("h_flush", pipe_flush, 1);
    chk("h_flush_id", pipe_flush_id, 4'h0);
    chk("h_busy", busy, 4'b0010);

    // Grant, completion and cancel on three requesters in one cycle.
    set_addr(3, 8'h33);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    chk("i_id3", pipe_id, 4'h3);
    chk("i_busy", busy, 4'b1010);
    set_addr(2, 8'h44);
    req_valid = 4'b0100;
    done_valid = 1'b1; done_id = 4'h1;
    cancel = 4'b1000;
    tick();
    req_valid = '0; done_valid = 1'b0; cancel = '0;
    chk("i_valid", pipe_valid, 1);
    chk("i_id2", pipe_id, 4'h2);
    chk("i_addr", pipe_address, 8'h44);
    chk("i_resp", resp_valid, 1);
    chk("i_resp_idx", resp_idx, 1);
    chk("i_flush", pipe_flush, 1);
    chk("i_flush_id", pipe_flush_id, 4'h3);
    chk("i_busy2", busy, 4'b0100);

    // Reset mid-operation is immediate and forgets everything.
    reset_n = 1'b0;
    #1;
    chk("j_busy", busy, 0);
    chk("j_valid", pipe_valid, 0);
    chk("j_flush", pipe_flush, 0);
    chk("j_resp", resp_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    done_valid = 1'b1; done_id = 4'h2;
    tick();
    done_valid = 1'b0;
    chk("j_no_resp", resp_valid, 0);
    chk("j_stale", stale_cnt, 1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("j_gen_rst", pipe_id, 4'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
